// File: rtl/top_level_pkg.sv
// rtl/top_level_pkg.sv - shared types, sizes and memory map for the lab-17 multiplier core
package top_level_pkg;

  localparam int DW       = 8;
  localparam int DM_DEPTH = 256;
  localparam int RF_DEPTH = 16;
  localparam int DM_AW    = 8;
  localparam int RF_AW    = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL,
    STORE,
    DONE
  } state_e;

  localparam logic [DM_AW-1:0] ADDR_A_HI = 8'd1;
  localparam logic [DM_AW-1:0] ADDR_A_LO = 8'd2;
  localparam logic [DM_AW-1:0] ADDR_B_HI = 8'd3;
  localparam logic [DM_AW-1:0] ADDR_B_LO = 8'd4;
  localparam logic [DM_AW-1:0] ADDR_P0   = 8'd5;
  localparam logic [DM_AW-1:0] ADDR_P1   = 8'd6;
  localparam logic [DM_AW-1:0] ADDR_P2   = 8'd7;
  localparam logic [DM_AW-1:0] ADDR_P3   = 8'd8;

  localparam logic [RF_AW-1:0] RF_OPND_BASE = 4'd1;
  localparam logic [RF_AW-1:0] RF_PROD_BASE = 4'd5;

  // Product byte k in store order: k=0 is the most significant byte.
  function automatic logic [DW-1:0] prod_byte(input logic [31:0] p, input logic [1:0] k);
    logic [DW-1:0] b;
    case (k)
      2'd0:    b = p[31:24];
      2'd1:    b = p[23:16];
      2'd2:    b = p[15:8];
      default: b = p[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/top_level_if.sv
// rtl/top_level_if.sv - Start/Ack handshake between the bench and the multiplier core
interface top_level_if;

  logic Start;
  logic Ack;

  modport master (output Start, input Ack);
  modport slave  (input Start, output Ack);

endinterface

// File: rtl/top_level_data_mem.sv
// rtl/top_level_data_mem.sv - 256x8 data memory, async read, sync write, contents not reset
module data_mem
  import top_level_pkg::*;
(
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [DM_AW-1:0] waddr_i,
  input  logic [DW-1:0]    wdata_i,
  input  logic [DM_AW-1:0] raddr_i,
  output logic [DW-1:0]    rdata_o
);

  logic [DW-1:0] Core [0:DM_DEPTH-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      Core[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = Core[raddr_i];

endmodule

// File: rtl/top_level_reg_file.sv
// rtl/top_level_reg_file.sv - 16x8 register file, one sync write port, contents not reset
module reg_file
  import top_level_pkg::*;
(
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [RF_AW-1:0] waddr_i,
  input  logic [DW-1:0]    wdata_i
);

  // Held as a directly observable array; no internal read path is needed by the core.
  logic [DW-1:0] Registers [0:RF_DEPTH-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      Registers[waddr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/top_level.sv
// rtl/top_level.sv - 16x16 unsigned shift-add multiplier reading/writing operands in data memory
module top_level
  import top_level_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  top_level_if.slave   hs
);

  state_e            state_q, state_d;
  logic              armed_q, armed_d;
  logic              ack_q, ack_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [15:0]       mcand_q, mcand_d;
  logic [15:0]       mplier_q, mplier_d;
  logic [31:0]       acc_q, acc_d;

  logic              dm_we;
  logic [DM_AW-1:0]  dm_waddr;
  logic [DW-1:0]     dm_wdata;
  logic [DM_AW-1:0]  dm_raddr;
  logic [DW-1:0]     dm_rdata;
  logic              rf_we;
  logic [RF_AW-1:0]  rf_waddr;
  logic [DW-1:0]     rf_wdata;

  data_mem DM1 (
    .clk_i   (Clk),
    .we_i    (dm_we),
    .waddr_i (dm_waddr),
    .wdata_i (dm_wdata),
    .raddr_i (dm_raddr),
    .rdata_o (dm_rdata)
  );

  reg_file RF1 (
    .clk_i   (Clk),
    .we_i    (rf_we),
    .waddr_i (rf_waddr),
    .wdata_i (rf_wdata)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      armed_q  <= 1'b0;
      ack_q    <= 1'b0;
      cnt_q    <= 5'd0;
      mcand_q  <= 16'd0;
      mplier_q <= 16'd0;
      acc_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      ack_q    <= ack_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    dm_we    = 1'b0;
    dm_raddr = ADDR_A_HI + {6'd0, cnt_q[1:0]};
    dm_waddr = ADDR_P0 + {6'd0, cnt_q[1:0]};
    dm_wdata = prod_byte(acc_q, cnt_q[1:0]);
    rf_we    = 1'b0;
    rf_waddr = RF_OPND_BASE + {2'd0, cnt_q[1:0]};
    rf_wdata = dm_rdata;

    case (state_q)
      IDLE: begin
        if (hs.Start) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d  = 1'b0;
          state_d  = LOAD;
          cnt_d    = 5'd0;
          mcand_d  = 16'd0;
          mplier_d = 16'd0;
          acc_d    = 32'd0;
        end
      end

      LOAD: begin
        if (hs.Start) begin
          state_d = IDLE;
          armed_d = 1'b1;
          cnt_d   = 5'd0;
        end else begin
          rf_we = 1'b1;
          // Operand registers are filled here so later DM writes cannot disturb the run.
          case (cnt_q[1:0])
            2'd0:    mcand_d[15:8]  = dm_rdata;
            2'd1:    mcand_d[7:0]   = dm_rdata;
            2'd2:    mplier_d[15:8] = dm_rdata;
            default: mplier_d[7:0]  = dm_rdata;
          endcase
          if (cnt_q == 5'd3) begin
            state_d = MUL;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      MUL: begin
        if (hs.Start) begin
          state_d = IDLE;
          armed_d = 1'b1;
          cnt_d   = 5'd0;
        end else begin
          if (mplier_q[cnt_q[3:0]]) begin
            acc_d = acc_q + ({16'd0, mcand_q} << cnt_q[3:0]);
          end
          if (cnt_q == 5'd15) begin
            state_d = STORE;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      STORE: begin
        if (hs.Start) begin
          state_d = IDLE;
          armed_d = 1'b1;
          cnt_d   = 5'd0;
        end else begin
          dm_we    = 1'b1;
          rf_we    = 1'b1;
          rf_waddr = RF_PROD_BASE + {2'd0, cnt_q[1:0]};
          rf_wdata = prod_byte(acc_q, cnt_q[1:0]);
          if (cnt_q == 5'd3) begin
            state_d = DONE;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      DONE: begin
        if (hs.Start) begin
          state_d = IDLE;
          armed_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ack_d = (state_d == DONE);
  end

  assign hs.Ack = ack_q;

endmodule

// File: tb/tb_top_level.sv
// tb/tb_top_level.sv - directed self-checking bench for the lab-17 multiplier core
module tb_top_level;
  import top_level_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  int   n_vec = 0;
  int   n_err = 0;

  top_level_if hs ();

  top_level dut (
    .Clk   (Clk),
    .Reset (Reset),
    .hs    (hs)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dm_checksum();
    logic [31:0] s;
    s = 32'(dut.DM1.Core[0]);
    for (int i = 9; i < 256; i++) begin
      s = s + (32'(dut.DM1.Core[i]) << (i % 13));
    end
    return s;
  endfunction

  task automatic set_ops(input logic [15:0] a, input logic [15:0] b);
    dut.DM1.Core[1] = a[15:8];
    dut.DM1.Core[2] = a[7:0];
    dut.DM1.Core[3] = b[15:8];
    dut.DM1.Core[4] = b[7:0];
  endtask

  // Arm with Start high, drop Start after a negedge; the first posedge after that is edge 1.
  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic [31:0] exp, input bit clobber);
    int n;
    bit seen;
    @(negedge Clk);
    hs.Start = 1'b1;
    set_ops(a, b);
    for (int i = 5; i <= 8; i++) dut.DM1.Core[i] = 8'h5A;
    @(negedge Clk);
    @(negedge Clk);
    hs.Start = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge Clk);
      n++;
      #1;
      if (hs.Ack) seen = 1'b1;
      if (clobber && n == 10) set_ops(~a, ~b);
    end
    check({tag, "_latency"}, 32'(n), 32'd25);
    check({tag, "_dm_prod"}, {dut.DM1.Core[5], dut.DM1.Core[6], dut.DM1.Core[7], dut.DM1.Core[8]}, exp);
    check({tag, "_rf_prod"}, {dut.RF1.Registers[5], dut.RF1.Registers[6],
                             dut.RF1.Registers[7], dut.RF1.Registers[8]}, exp);
    check({tag, "_rf_opnd"}, {dut.RF1.Registers[1], dut.RF1.Registers[2],
                             dut.RF1.Registers[3], dut.RF1.Registers[4]}, {a, b});
  endtask

  initial begin
    logic [31:0] sum_before;
    hs.Start = 1'b0;
    Reset = 1'b1;
    for (int i = 0; i < 256; i++) dut.DM1.Core[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 16; i++) dut.RF1.Registers[i] = 8'h00;
    #9;
    check("reset_ack", 32'(hs.Ack), 32'd0);
    check("reset_state", 32'(dut.state_q), 32'(IDLE));
    #1;
    Reset = 1'b0;

    run("a03ff_bfffb", 16'h03FF, 16'hFFFB, 32'h03FE_EC05, 1'b0);
    run("a0000_b1234", 16'h0000, 16'h1234, 32'h0000_0000, 1'b0);
    run("affff_bffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0);

    sum_before = dm_checksum();
    run("a0001_b0001", 16'h0001, 16'h0001, 32'h0000_0001, 1'b0);
    check("untouched_bytes", dm_checksum(), sum_before);

    // Reset in the middle of MUL must drop Ack and the FSM at once.
    @(negedge Clk);
    hs.Start = 1'b1;
    set_ops(16'h1111, 16'h2222);
    @(negedge Clk);
    @(negedge Clk);
    hs.Start = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    check("mid_run_state", 32'(dut.state_q), 32'(MUL));
    #1;
    Reset = 1'b1;
    #1;
    check("mid_rst_ack", 32'(hs.Ack), 32'd0);
    check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge Clk);
    Reset = 1'b0;
    run("after_rst", 16'h1234, 16'h5678, 32'h0626_0060, 1'b0);

    for (int i = 0; i < 20; i++) begin
      @(posedge Clk);
      #1;
      check($sformatf("ack_hold_%0d", i), 32'(hs.Ack), 32'd1);
    end
    @(negedge Clk);
    hs.Start = 1'b1;
    @(posedge Clk);
    #1;
    check("ack_drop", 32'(hs.Ack), 32'd0);
    check("drop_state", 32'(dut.state_q), 32'(IDLE));

    run("rerun_clobber", 16'h1234, 16'h5678, 32'h0626_0060, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
